// File: rtl/vga_timing_pkg.sv
// Shared FSM state type, default 640x480@60 raster timing and a raster-length helper
// for the VGA timing generator.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// pix_en-gated shift register that lines up sync/DE/strobes with the pixel-data pipeline.
// Each bit resets to its own inactive level; zero depth is a plain wire.
module vga_sync_delay #(
  parameter int                 PIPE_DLY = 0,
  parameter int                 WIDTH    = 5,
  parameter logic [WIDTH-1:0]   RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_pix_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (PIPE_DLY == 0) begin : g_bypass
      logic w_unused;
      assign w_unused = ^{clk, reset, i_pix_en};
      assign o_data   = i_data;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [PIPE_DLY];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < PIPE_DLY; k++) r_stage[k] <= RST_VAL;
        end else if (i_pix_en) begin
          r_stage[0] <= i_data;
          for (int k = 1; k < PIPE_DLY; k++) r_stage[k] <= r_stage[k-1];
        end
      end

      assign o_data = r_stage[PIPE_DLY-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: run/stop FSM, h/v counters, sync/DE decode,
// registered outputs and an optional alignment delay on sync/DE/strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CNT_W    = 10,
  parameter int PIPE_DLY = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_pix_en,
  input  logic             i_run,
  output logic             o_h_sync,
  output logic             o_v_sync,
  output logic             o_de,
  output logic [CNT_W-1:0] o_x_pixel,
  output logic [CNT_W-1:0] o_y_pixel,
  output logic             o_line_start,
  output logic             o_frame_start,
  output logic             o_busy
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int CW1     = CNT_W + 1;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Decode bounds are one bit wider so a sync region ending exactly at TOTAL cannot wrap.
  localparam logic [CNT_W:0] H_ACT_E  = CW1'(H_ACTIVE);
  localparam logic [CNT_W:0] H_SYNC_S = CW1'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] H_SYNC_E = CW1'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] V_ACT_E  = CW1'(V_ACTIVE);
  localparam logic [CNT_W:0] V_SYNC_S = CW1'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] V_SYNC_E = CW1'(V_ACTIVE + V_FP + V_SYNC);

  generate
    if ((1 << CNT_W) < H_TOTAL || (1 << CNT_W) < V_TOTAL) begin : g_cnt_w_check
      $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_dly_check
      $error("vga_timing_gen: PIPE_DLY must be in 0..7");
    end
  endgenerate

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_h_cnt, r_v_cnt, w_h_nxt, w_v_nxt;
  logic             w_h_last, w_last_pix;

  assign w_h_last   = (r_h_cnt == H_LAST);
  assign w_last_pix = w_h_last && (r_v_cnt == V_LAST);

  // A dropped run only ends the frame at its last pixel; run raised again resumes seamlessly.
  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = r_h_cnt;
    w_v_nxt     = r_v_cnt;
    unique case (r_state)
      IDLE: begin
        w_h_nxt = '0;
        w_v_nxt = '0;
        if (i_run) w_state_nxt = RUN;
      end
      RUN, DRAIN: begin
        if (w_h_last) begin
          w_h_nxt = '0;
          w_v_nxt = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
          w_h_nxt = r_h_cnt + 1'b1;
        end
        if (i_run)           w_state_nxt = RUN;
        else if (w_last_pix) w_state_nxt = IDLE;
        else                 w_state_nxt = DRAIN;
      end
      default: begin
        w_state_nxt = IDLE;
        w_h_nxt     = '0;
        w_v_nxt     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (i_pix_en) begin
      r_state <= w_state_nxt;
      r_h_cnt <= w_h_nxt;
      r_v_cnt <= w_v_nxt;
    end
  end

  logic w_counting, w_de, w_hs_act, w_vs_act, w_line_start, w_frame_start;

  assign w_counting    = (r_state != IDLE);
  assign w_de          = w_counting && ({1'b0, r_h_cnt} < H_ACT_E) && ({1'b0, r_v_cnt} < V_ACT_E);
  assign w_hs_act      = w_counting && ({1'b0, r_h_cnt} >= H_SYNC_S) && ({1'b0, r_h_cnt} < H_SYNC_E);
  assign w_vs_act      = w_counting && ({1'b0, r_v_cnt} >= V_SYNC_S) && ({1'b0, r_v_cnt} < V_SYNC_E);
  assign w_line_start  = w_counting && (r_h_cnt == '0);
  assign w_frame_start = w_line_start && (r_v_cnt == '0);

  logic             r_h_sync, r_v_sync, r_de, r_line_start, r_frame_start, r_busy;
  logic [CNT_W-1:0] r_x_pixel, r_y_pixel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h_sync      <= ~H_POL;
      r_v_sync      <= ~V_POL;
      r_de          <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_x_pixel     <= '0;
      r_y_pixel     <= '0;
      r_busy        <= 1'b0;
    end else if (i_pix_en) begin
      r_h_sync      <= w_hs_act ? H_POL : ~H_POL;
      r_v_sync      <= w_vs_act ? V_POL : ~V_POL;
      r_de          <= w_de;
      r_line_start  <= w_line_start;
      r_frame_start <= w_frame_start;
      r_x_pixel     <= r_h_cnt;
      r_y_pixel     <= r_v_cnt;
      r_busy        <= (w_state_nxt != IDLE);
    end
  end

  logic [4:0] w_dly_out;

  vga_sync_delay #(
    .PIPE_DLY (PIPE_DLY),
    .WIDTH    (5),
    .RST_VAL  ({~H_POL, ~V_POL, 3'b000})
  ) u_sync_delay (
    .clk      (clk),
    .reset    (reset),
    .i_pix_en (i_pix_en),
    .i_data   ({r_h_sync, r_v_sync, r_de, r_line_start, r_frame_start}),
    .o_data   (w_dly_out)
  );

  assign {o_h_sync, o_v_sync, o_de, o_line_start, o_frame_start} = w_dly_out;
  assign o_x_pixel = r_x_pixel;
  assign o_y_pixel = r_y_pixel;
  assign o_busy    = r_busy;

endmodule
